tone_sample_writer: RTL
=======================

// Module: tone_sample_writer
// PURPOSE
//  Downstream of the note square-wave generator, upstream of audio_codec. Syncs the note
//  square wave and key-held flag into the clock domain and shapes amplitude with an
//  attack/sustain/release envelope. Emits signed 24-bit samples to the codec via write/write_ready,
//  one sample per accepted write. Sample rate is set by codec FIFO drain; envelope steps once per sample.
// PARAMETERS
//  AMP_W         16  envelope amplitude width; must be <= 23
//  ATTACK_STEP   64  amplitude increment per accepted sample in ATTACK
//  RELEASE_STEP  32  amplitude decrement per accepted sample in RELEASE
//  SYNC_STAGES   2   flip-flop stages on note_clock / note_active (>= 2)
// PORTS
//  clock            in   1   system clock (CLOCK_50 domain)
//  resetn           in   1   async active-low reset
//  enable           in   1   playback enable (SW[0]); low = silence, no writes
//  note_clock       in   1   async square wave from note generator
//  note_active      in   1   async; high while a note key is held (note_leds != 0)
//  volume           in   4   linear gain, effective gain (volume+1)/16
//  write_ready      in   1   codec DAC FIFO has space
//  write            out  1   one-cycle sample write strobe to codec
//  writedata_left   out  24  signed left sample
//  writedata_right  out  24  signed right sample
// BEHAVIOUR
//  Reset: write=0, writedata_*=0, amp=0, env=ENV_IDLE, hs=HS_WAIT.
//  Sync: both async inputs pass SYNC_STAGES flops (tsw_sync); sq, act = synced values.
//  Handshake FSM: HS_WAIT -> HS_WRITE when enable & write_ready; HS_WRITE asserts write for exactly
//   1 cycle, data valid same cycle -> HS_HOLD (1 cycle, write=0, lets write_ready update) -> HS_WAIT.
//   Never two writes in consecutive cycles.
//  Sample: scaled = (amp*(volume+1))>>4, AMP_W bits; mag = {1'b0, scaled, (23-AMP_W)'b0};
//   data = sq ? mag : -mag (two's complement); left == right. Computed and registered in HS_WAIT on
//   the cycle write_ready is seen, held through HS_WRITE. Volume/sq changes apply to next sample only.
//  Envelope (advances only in the HS_WRITE cycle):
//   ENV_IDLE:    amp=0; act -> ENV_ATTACK.
//   ENV_ATTACK:  amp += ATTACK_STEP, saturate at AMP_MAX -> ENV_SUSTAIN; !act -> ENV_RELEASE.
//   ENV_SUSTAIN: amp held; !act -> ENV_RELEASE.
//   ENV_RELEASE: amp <= RELEASE_STEP -> amp=0, ENV_IDLE; else amp -= RELEASE_STEP;
//                act re-asserted -> ENV_ATTACK from current amp (no click to 0).
//  ENV_IDLE writes zero samples (codec keeps draining; no underrun).
//  enable low: next cycle write=0, hs=HS_WAIT, env=ENV_IDLE, amp=0, data=0. Mid-HS_WRITE drop
//   still ends write after its single cycle; no second strobe.
//  resetn asserted mid-write: write drops immediately (async).
// CONFIGURATION
//  TSW_PAN_EN defined: extra input pan[1:0]; 0 centre, 1 left only (right=0), 2 right only
//   (left=0), 3 centre at half gain (both >>>1, arithmetic). Not defined: no pan port, left==right.
// STRUCTURE
//  Package tsw_pkg: env_state_t {ENV_IDLE,ENV_ATTACK,ENV_SUSTAIN,ENV_RELEASE}, hs_state_t
//   {HS_WAIT,HS_WRITE,HS_HOLD}, SAMPLE_W=24, pan codes.
//   AMP_MAX = 2**AMP_W-1: localparam in the module (AMP_W-dependent).
//  Sub-module tsw_sync: parameterised SYNC_STAGES multi-bit (per-bit) synchroniser, reset to 0.
// TESTING
//  1 Reset, enable=1, write_ready=1, act=0 -> writes every 3 cycles, data=0, env IDLE.
//  2 act=1, sq=1, vol=15, ready=1 -> amp 64,128,...; saturates 65535 on write 1024;
//    data 24'h7FFF80, sq=0 gives 24'h800080; env SUSTAIN.
//  3 From sustain, act=0 -> amp drops 32/sample; reaches 0 on write 2048; env IDLE.
//  4 ready=0 for 100 cycles -> write stays 0, amp frozen; ready=1 -> first write within 2 cycles.
//  5 Attack at amp=640, act drops 1 write, returns -> RELEASE 608 then ATTACK 672; no jump to 0.
//  6 enable low mid-HS_WRITE -> one strobe only, then data=0, amp=0; TSW_PAN_EN pan=1 -> right=0.

Source files
------------

// File: rtl/tsw_pkg.sv
// Shared types and constants for the tone sample writer: envelope and
// handshake state encodings, sample width and pan codes.
package tsw_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  typedef enum logic [1:0] {
    HS_WAIT  = 2'd0,
    HS_WRITE = 2'd1,
    HS_HOLD  = 2'd2
  } hs_state_t;

  typedef enum logic [1:0] {
    PAN_CENTRE = 2'd0,
    PAN_LEFT   = 2'd1,
    PAN_RIGHT  = 2'd2,
    PAN_HALF   = 2'd3
  } pan_t;

  // A square-wave low phase is the negated magnitude, so the wave is symmetric about zero.
  function automatic logic [SAMPLE_W-1:0] apply_polarity(input logic [SAMPLE_W-1:0] mag,
                                                         input logic sq);
    return sq ? mag : -mag;
  endfunction

endpackage

// File: rtl/tone_sample_writer_if.sv
// Codec-side sample bus: one-cycle write strobe with stereo data, gated by
// the codec's FIFO-space flag.
interface tone_sample_writer_if;
  import tsw_pkg::*;

  logic                write_ready;
  logic                write;
  logic [SAMPLE_W-1:0] writedata_left;
  logic [SAMPLE_W-1:0] writedata_right;

  modport master (
    input  write_ready,
    output write,
    output writedata_left,
    output writedata_right
  );

  modport slave (
    output write_ready,
    input  write,
    input  writedata_left,
    input  writedata_right
  );

endinterface

// File: rtl/tsw_sync.sv
// Per-bit multi-stage synchroniser for asynchronous level inputs; all stages
// clear to 0 on reset.
module tsw_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES*WIDTH-1:0] chain_q;
  logic [STAGES*WIDTH-1:0] chain_d;

  // Newest sample enters at the bottom; the oldest stage is the synchronised output.
  always_comb begin
    chain_d = {chain_q[(STAGES-1)*WIDTH-1:0], d};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/tone_sample_writer.sv
// Envelope-shaped square-wave sample source feeding the audio codec FIFO.
// Optional TSW_PAN_EN adds a pan[1:0] input for left/right/half-gain placement.
module tone_sample_writer
  import tsw_pkg::*;
#(
  parameter int AMP_W        = 16,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       note_clock,
  input  logic                       note_active,
  input  logic [3:0]                 volume,
`ifdef TSW_PAN_EN
  input  logic [1:0]                 pan,
`endif
  tone_sample_writer_if.master       codec
);

  localparam logic [AMP_W-1:0] AMP_MAX     = {AMP_W{1'b1}};
  localparam logic [AMP_W:0]   ATTACK_INC  = (AMP_W+1)'(ATTACK_STEP);
  localparam logic [AMP_W-1:0] RELEASE_DEC = AMP_W'(RELEASE_STEP);
  localparam int               MAG_SHIFT   = SAMPLE_W - 1 - AMP_W;

  logic [1:0] sync_out;
  logic       sq;
  logic       act;

  tsw_sync #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      ({note_clock, note_active}),
    .q      (sync_out)
  );

  assign sq  = sync_out[1];
  assign act = sync_out[0];

  hs_state_t           hs_q, hs_d;
  env_state_t          env_q, env_d;
  logic [AMP_W-1:0]    amp_q, amp_d;
  logic                write_q, write_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] right_q, right_d;

  logic [4:0]          gain;
  logic [AMP_W+4:0]    product;
  logic [AMP_W-1:0]    scaled;
  logic [SAMPLE_W-1:0] mag;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] left_s;
  logic [SAMPLE_W-1:0] right_s;
  logic [AMP_W:0]      attack_sum;

  // Gain is (volume+1)/16, so the product never exceeds AMP_W bits after the shift.
  always_comb begin
    gain    = {1'b0, volume} + 5'd1;
    product = (AMP_W+5)'(amp_q) * (AMP_W+5)'(gain);
    scaled  = AMP_W'(product >> 4);
    mag     = SAMPLE_W'(scaled) << MAG_SHIFT;
    sample  = apply_polarity(mag, sq);
  end

`ifdef TSW_PAN_EN
  always_comb begin
    left_s  = sample;
    right_s = sample;
    case (pan_t'(pan))
      PAN_LEFT:  right_s = '0;
      PAN_RIGHT: left_s  = '0;
      PAN_HALF: begin
        left_s  = SAMPLE_W'($signed(sample) >>> 1);
        right_s = SAMPLE_W'($signed(sample) >>> 1);
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    left_s  = sample;
    right_s = sample;
  end
`endif

  // Sample is latched on entry to HS_WRITE; the envelope steps during HS_WRITE so the
  // new amplitude only affects the following sample. Disable forces everything quiet.
  always_comb begin
    hs_d       = hs_q;
    env_d      = env_q;
    amp_d      = amp_q;
    write_d    = 1'b0;
    left_d     = left_q;
    right_d    = right_q;
    attack_sum = {1'b0, amp_q} + ATTACK_INC;

    case (hs_q)
      HS_WAIT: begin
        if (enable && codec.write_ready) begin
          hs_d    = HS_WRITE;
          write_d = 1'b1;
          left_d  = left_s;
          right_d = right_s;
        end
      end
      HS_WRITE: begin
        hs_d = HS_HOLD;
        case (env_q)
          ENV_IDLE: begin
            amp_d = '0;
            if (act) env_d = ENV_ATTACK;
          end
          ENV_ATTACK: begin
            if (!act) begin
              env_d = ENV_RELEASE;
            end else if (attack_sum >= {1'b0, AMP_MAX}) begin
              amp_d = AMP_MAX;
              env_d = ENV_SUSTAIN;
            end else begin
              amp_d = attack_sum[AMP_W-1:0];
            end
          end
          ENV_SUSTAIN: begin
            if (!act) env_d = ENV_RELEASE;
          end
          ENV_RELEASE: begin
            if (act) begin
              env_d = ENV_ATTACK;
            end else if (amp_q <= RELEASE_DEC) begin
              amp_d = '0;
              env_d = ENV_IDLE;
            end else begin
              amp_d = amp_q - RELEASE_DEC;
            end
          end
          default: env_d = ENV_IDLE;
        endcase
      end
      HS_HOLD: hs_d = HS_WAIT;
      default: hs_d = HS_WAIT;
    endcase

    if (!enable) begin
      hs_d    = HS_WAIT;
      env_d   = ENV_IDLE;
      amp_d   = '0;
      write_d = 1'b0;
      left_d  = '0;
      right_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hs_q    <= HS_WAIT;
      env_q   <= ENV_IDLE;
      amp_q   <= '0;
      write_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      hs_q    <= hs_d;
      env_q   <= env_d;
      amp_q   <= amp_d;
      write_q <= write_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign codec.write           = write_q;
  assign codec.writedata_left  = left_q;
  assign codec.writedata_right = right_q;

endmodule
